// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - vending transaction sequencer; VEND_TIMEOUT_EN enables inactivity auto-refund
module vend_sequencer #(
  parameter int VM_LATENCY     = 1,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [7:0] coin_value,
  input  logic       sel_valid,
  input  logic [3:0] sel_code,
  input  logic       cancel,
  input  logic       change_ack,
  input  logic       vm_dispense,
  input  logic [7:0] vm_balance,
  output logic       vm_req,
  output logic [7:0] vm_amount,
  output logic [3:0] vm_item,
  output logic [7:0] credit,
  output logic       busy,
  output logic       coin_reject,
  output logic       vend_done,
  output logic       vend_fail,
  output logic       change_valid,
  output logic [7:0] change_amount,
  output logic       timeout
);

  if (VM_LATENCY < 1 || VM_LATENCY > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("vend_sequencer: parameter out of range");
  end

  localparam logic [3:0] LAT = 4'(VM_LATENCY);

  typedef enum logic [2:0] {IDLE, CREDIT, ISSUE, WAIT, CHANGE} state_t;

  state_t     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic [3:0] item_q, item_d;
  logic [7:0] chg_q, chg_d;
  logic [3:0] lat_q, lat_d;
  logic       coin_reject_q, coin_reject_d;
  logic       vend_done_q, vend_done_d;
  logic       vend_fail_q, vend_fail_d;
  logic [8:0] coin_sum;
  logic       coin_taken;

`ifdef VEND_TIMEOUT_EN
  localparam logic [16:0] TMO = 17'(TIMEOUT_CYCLES);
  logic [15:0] tmo_q, tmo_d;
  logic [16:0] tmo_next;
  logic        timeout_q, timeout_d;
`endif

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    item_d        = item_q;
    chg_d         = chg_q;
    lat_d         = lat_q;
    coin_reject_d = 1'b0;
    vend_done_d   = 1'b0;
    vend_fail_d   = 1'b0;
    coin_taken    = 1'b0;
    coin_sum      = {1'b0, credit_q} + {1'b0, coin_value};
`ifdef VEND_TIMEOUT_EN
    tmo_d     = tmo_q;
    timeout_d = 1'b0;
    tmo_next  = {1'b0, tmo_q} + 17'd1;
`endif
    case (state_q)
      IDLE: begin
        if (coin_valid && coin_value != 8'd0) begin
          credit_d = coin_value;
          state_d  = CREDIT;
`ifdef VEND_TIMEOUT_EN
          tmo_d = 16'd0;
`endif
        end
      end
      CREDIT: begin
        // cancel beats selection beats coin; a coin losing arbitration is bounced
        if (cancel) begin
          coin_reject_d = coin_valid;
          chg_d         = credit_q;
          state_d       = CHANGE;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (sel_code == 4'd0 || sel_code > 4'd10) begin
            vend_fail_d = 1'b1;
          end else begin
            item_d  = sel_code;
            state_d = ISSUE;
          end
        end else if (coin_valid) begin
          if (coin_sum[8]) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d   = coin_sum[7:0];
            coin_taken = 1'b1;
          end
        end
`ifdef VEND_TIMEOUT_EN
        if (coin_taken) begin
          tmo_d = 16'd0;
        end else if (state_d == CREDIT) begin
          if (tmo_next == TMO) begin
            timeout_d = 1'b1;
            chg_d     = credit_q;
            state_d   = CHANGE;
          end else begin
            tmo_d = tmo_next[15:0];
          end
        end
`endif
      end
      ISSUE: begin
        coin_reject_d = coin_valid;
        lat_d         = 4'd1;
        state_d       = WAIT;
      end
      WAIT: begin
        coin_reject_d = coin_valid;
        if (lat_q == LAT) begin
          // a balance above the deposit is treated as a refusal
          if (vm_dispense && vm_balance <= credit_q) begin
            vend_done_d = 1'b1;
            chg_d       = vm_balance;
          end else begin
            vend_fail_d = 1'b1;
            chg_d       = credit_q;
          end
          state_d = CHANGE;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        if (chg_q == 8'd0 || change_ack) begin
          credit_d = 8'd0;
          chg_d    = 8'd0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      credit_q      <= 8'd0;
      item_q        <= 4'd0;
      chg_q         <= 8'd0;
      lat_q         <= 4'd0;
      coin_reject_q <= 1'b0;
      vend_done_q   <= 1'b0;
      vend_fail_q   <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      tmo_q     <= 16'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      item_q        <= item_d;
      chg_q         <= chg_d;
      lat_q         <= lat_d;
      coin_reject_q <= coin_reject_d;
      vend_done_q   <= vend_done_d;
      vend_fail_q   <= vend_fail_d;
`ifdef VEND_TIMEOUT_EN
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign vm_req        = (state_q == ISSUE);
  assign vm_amount     = (state_q == ISSUE || state_q == WAIT) ? credit_q : 8'd0;
  assign vm_item       = (state_q == ISSUE || state_q == WAIT) ? item_q : 4'd0;
  assign credit        = credit_q;
  assign busy          = (state_q == ISSUE || state_q == WAIT || state_q == CHANGE);
  assign coin_reject   = coin_reject_q;
  assign vend_done     = vend_done_q;
  assign vend_fail     = vend_fail_q;
  assign change_valid  = (state_q == CHANGE) && (chg_q != 8'd0);
  assign change_amount = (state_q == CHANGE) ? chg_q : 8'd0;
`ifdef VEND_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
